// File: rtl/k2red_pkg.sv
// Shared definitions for the K2-RED transmit path: default widths, the feeder
// FSM encoding, and a helper that builds a Proth modulus from its shift terms.
package k2red_pkg;

  localparam int LOG_Q_DEF = 32;
  localparam int M_DEF     = 17;
  localparam int LOG_L_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // q = k*2^m + 1 with k = 2^(log_q-1-m) + 2^l1 - 2^l2 + 2^l3
  function automatic logic [63:0] k2red_q(input int log_q, input int m,
                                          input int l1, input int l2, input int l3);
    logic [63:0] k;
    k = (64'd1 << (log_q - 1 - m)) + (64'd1 << l1) - (64'd1 << l2) + (64'd1 << l3);
    return (k << m) + 64'd1;
  endfunction

endpackage

// File: rtl/k2red_digit_mac.sv
// One digit step of the serial multiplier: (acc << DIGIT) + x * digit.
// Kept combinational and separate so the digit width can be retimed on its own.
module k2red_digit_mac #(
  parameter int LOG_Q = 32,
  parameter int DIGIT = 8
) (
  input  logic [2*LOG_Q-1:0] acc_i,
  input  logic [LOG_Q-1:0]   x_i,
  input  logic [DIGIT-1:0]   digit_i,
  output logic [2*LOG_Q-1:0] acc_o
);

  logic [LOG_Q+DIGIT-1:0] pp;

  assign pp = (LOG_Q + DIGIT)'(x_i) * (LOG_Q + DIGIT)'(digit_i);

  // The bits shifted out of acc are always zero: after j digits acc < 2^(LOG_Q+j*DIGIT).
  assign acc_o = (acc_i << DIGIT) + (2 * LOG_Q)'(pp);

endmodule

// File: rtl/k2red_mul_feeder.sv
// Transmit side of the K2-RED reducer stream: accepts (X,Y), multiplies them
// digit-serially and emits {A, Q, l1, l2, l3} with a one-cycle valid pulse.
module k2red_mul_feeder
  import k2red_pkg::*;
#(
  parameter int LOG_Q  = LOG_Q_DEF,
  parameter int M      = M_DEF,
  parameter int LOG_L  = LOG_L_DEF,
  parameter int USE_L3 = 1,
  parameter int DIGIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [LOG_Q-1:0]     cfg_q,
  input  logic [LOG_L-1:0]     cfg_l1,
  input  logic [LOG_L-1:0]     cfg_l2,
  input  logic [LOG_L-1:0]     cfg_l3,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [LOG_Q-1:0]     X,
  input  logic [LOG_Q-1:0]     Y,
  output logic [2*LOG_Q-1:0]   A,
  output logic [LOG_Q-1:0]     Q,
  output logic [LOG_L-1:0]     l1,
  output logic [LOG_L-1:0]     l2,
  output logic [LOG_L-1:0]     l3,
  output logic                 valid_out,
  output logic [1:0]           dbg_state
);

  localparam int NDIG = LOG_Q / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int AW   = 2 * LOG_Q;

  if (LOG_Q % DIGIT != 0) begin : g_bad_digit
    $error("k2red_mul_feeder: LOG_Q must be a multiple of DIGIT");
  end
  if (M > LOG_Q - 1) begin : g_bad_m
    $error("k2red_mul_feeder: M must not exceed LOG_Q-1");
  end

  // Handshake: a transfer happens at a rising edge where valid_in && ready_in.
  // ready_in is high in IDLE and OUT (never under rst); X/Y must be held until taken.
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LOG_Q-1:0]  x_q, x_d;
  logic [LOG_Q-1:0]  y_q, y_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     mac_out;

  logic [LOG_Q-1:0]  cfg_mod_q, cfg_mod_d;
  logic [LOG_L-1:0]  cfg_l1_q, cfg_l1_d;
  logic [LOG_L-1:0]  cfg_l2_q, cfg_l2_d;
  logic [LOG_L-1:0]  cfg_l3_q, cfg_l3_d;

  logic [LOG_Q-1:0]  snap_mod_q, snap_mod_d;
  logic [LOG_L-1:0]  snap_l1_q, snap_l1_d;
  logic [LOG_L-1:0]  snap_l2_q, snap_l2_d;
  logic [LOG_L-1:0]  snap_l3_q, snap_l3_d;

  logic [AW-1:0]     a_q, a_d;
  logic [LOG_Q-1:0]  mod_q, mod_d;
  logic [LOG_L-1:0]  l1_q, l1_d;
  logic [LOG_L-1:0]  l2_q, l2_d;
  logic [LOG_L-1:0]  l3_q, l3_d;
  logic              valid_q, valid_d;

  logic              accept;

  assign ready_in = !rst && ((state_q == S_IDLE) || (state_q == S_OUT));
  assign accept   = valid_in && ready_in;

  k2red_digit_mac #(
    .LOG_Q (LOG_Q),
    .DIGIT (DIGIT)
  ) u_mac (
    .acc_i   (acc_q),
    .x_i     (x_q),
    .digit_i (y_q[cnt_q*DIGIT +: DIGIT]),
    .acc_o   (mac_out)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    cfg_mod_d  = cfg_mod_q;
    cfg_l1_d   = cfg_l1_q;
    cfg_l2_d   = cfg_l2_q;
    cfg_l3_d   = cfg_l3_q;
    snap_mod_d = snap_mod_q;
    snap_l1_d  = snap_l1_q;
    snap_l2_d  = snap_l2_q;
    snap_l3_d  = snap_l3_q;
    a_d        = a_q;
    mod_d      = mod_q;
    l1_d       = l1_q;
    l2_d       = l2_q;
    l3_d       = l3_q;
    valid_d    = 1'b0;

    if (cfg_we) begin
      cfg_mod_d = cfg_q;
      cfg_l1_d  = cfg_l1;
      cfg_l2_d  = cfg_l2;
      cfg_l3_d  = cfg_l3;
    end

    case (state_q)
      S_IDLE: begin
      end
      S_MUL: begin
        acc_d = mac_out;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_OUT;
      end
      S_OUT: begin
        a_d     = acc_q;
        mod_d   = snap_mod_q;
        l1_d    = snap_l1_q;
        l2_d    = snap_l2_q;
        l3_d    = (USE_L3 != 0) ? snap_l3_q : '0;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot takes the registered config, so a same-edge cfg_we applies to the next op.
    if (accept) begin
      state_d    = S_MUL;
      cnt_d      = CW'(NDIG - 1);
      x_d        = X;
      y_d        = Y;
      acc_d      = '0;
      snap_mod_d = cfg_mod_q;
      snap_l1_d  = cfg_l1_q;
      snap_l2_d  = cfg_l2_q;
      snap_l3_d  = cfg_l3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      cfg_mod_q  <= '0;
      cfg_l1_q   <= '0;
      cfg_l2_q   <= '0;
      cfg_l3_q   <= '0;
      snap_mod_q <= '0;
      snap_l1_q  <= '0;
      snap_l2_q  <= '0;
      snap_l3_q  <= '0;
      a_q        <= '0;
      mod_q      <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      l3_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      cfg_mod_q  <= cfg_mod_d;
      cfg_l1_q   <= cfg_l1_d;
      cfg_l2_q   <= cfg_l2_d;
      cfg_l3_q   <= cfg_l3_d;
      snap_mod_q <= snap_mod_d;
      snap_l1_q  <= snap_l1_d;
      snap_l2_q  <= snap_l2_d;
      snap_l3_q  <= snap_l3_d;
      a_q        <= a_d;
      mod_q      <= mod_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      l3_q       <= l3_d;
      valid_q    <= valid_d;
    end
  end

  assign A         = a_q;
  assign Q         = mod_q;
  assign l1        = l1_q;
  assign l2        = l2_q;
  assign l3        = l3_q;
  assign valid_out = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_k2red_mul_feeder.sv
// Bench for k2red_mul_feeder: directed handshake/config/reset cases plus random
// products, compared against a transaction-level model of the feeder.
module tb_k2red_mul_feeder;
  import k2red_pkg::*;

  localparam int NDIG = 4;
  localparam int LAT  = NDIG + 1;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] q;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic [3:0]  l3;
    logic [31:0] due;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cfg_we;
  logic [31:0] cfg_q;
  logic [3:0]  cfg_l1, cfg_l2, cfg_l3;
  logic        valid_in;
  logic [31:0] X, Y;

  logic        ready_in, valid_out;
  logic [63:0] A;
  logic [31:0] Q;
  logic [3:0]  l1, l2, l3;
  logic [1:0]  dbg_state;

  logic        r0, v0;
  logic [63:0] a0;
  logic [31:0] q0;
  logic [3:0]  l10, l20, l30;
  logic [1:0]  s0;

  k2red_mul_feeder #(.LOG_Q(32), .M(17), .LOG_L(4), .USE_L3(1), .DIGIT(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_l1(cfg_l1),
    .cfg_l2(cfg_l2), .cfg_l3(cfg_l3), .valid_in(valid_in), .ready_in(ready_in),
    .X(X), .Y(Y), .A(A), .Q(Q), .l1(l1), .l2(l2), .l3(l3),
    .valid_out(valid_out), .dbg_state(dbg_state)
  );

  k2red_mul_feeder #(.LOG_Q(32), .M(17), .LOG_L(4), .USE_L3(0), .DIGIT(8)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_l1(cfg_l1),
    .cfg_l2(cfg_l2), .cfg_l3(cfg_l3), .valid_in(valid_in), .ready_in(r0),
    .X(X), .Y(Y), .A(a0), .Q(q0), .l1(l10), .l2(l20), .l3(l30),
    .valid_out(v0), .dbg_state(s0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: model of config register, busy window and expected output pulses
  exp_t        exp_q[$];
  int          edge_n = 0;
  int          busy_until = 0;
  int          last_acc = 0;
  logic [31:0] m_q;
  logic [3:0]  m_l1, m_l2, m_l3;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    logic ready_exp, exp_v;
    exp_t e;
    while (exp_q.size() > 0 && int'(exp_q[0].due) < edge_n) begin
      check("lost_product_due", 64'(exp_q[0].due), 64'(edge_n));
      void'(exp_q.pop_front());
    end
    ready_exp = !rst && (edge_n >= busy_until);
    check("ready_in", ready_in, ready_exp);
    check("ready_in_l3off", r0, ready_exp);
    exp_v = (exp_q.size() > 0) && (int'(exp_q[0].due) == edge_n);
    if (valid_out || v0 || exp_v) begin
      check("valid_out", valid_out, exp_v);
      check("valid_out_l3off", v0, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        check("A", A, e.a);
        check("Q", Q, e.q);
        check("l1", l1, e.l1);
        check("l2", l2, e.l2);
        check("l3", l3, e.l3);
        check("A_l3off", a0, e.a);
        check("Q_l3off", q0, e.q);
        check("l1_l3off", l10, e.l1);
        check("l3_forced_zero", l30, 4'd0);
      end
    end
    // model what the coming edge does
    if (rst) begin
      exp_q.delete();
      busy_until = 0;
      m_q = '0; m_l1 = '0; m_l2 = '0; m_l3 = '0;
    end else begin
      if (valid_in && ready_exp) begin
        e.a   = 64'(X) * 64'(Y);
        e.q   = m_q;
        e.l1  = m_l1;
        e.l2  = m_l2;
        e.l3  = m_l3;
        e.due = 32'(edge_n + 1 + LAT);
        exp_q.push_back(e);
        last_acc   = edge_n + 1;
        busy_until = edge_n + 1 + NDIG;
      end
      if (cfg_we) begin
        m_q = cfg_q; m_l1 = cfg_l1; m_l2 = cfg_l2; m_l3 = cfg_l3;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    X = x;
    Y = y;
    valid_in = 1'b1;
    while (!done && n < 64) begin
      @(negedge clk);
      if (ready_in) done = 1'b1;
      tick();
      n++;
    end
    valid_in = 1'b0;
    if (!done) check("send_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  task automatic load_cfg(input logic [31:0] q, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c);
    cfg_we = 1'b1; cfg_q = q; cfg_l1 = a; cfg_l2 = b; cfg_l3 = c;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e1, e2;
    logic [31:0] cur_q;
    logic [3:0]  ra, rb, rc;

    rst = 1'b1; cfg_we = 1'b0; cfg_q = '0; cfg_l1 = '0; cfg_l2 = '0; cfg_l3 = '0;
    valid_in = 1'b0; X = '0; Y = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", ready_in, 1'b0);
    check("rst_A", A, 64'd0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready_in, 1'b1);
    tick();

    // 1: basic product and latency
    cur_q = 32'(k2red_q(32, 17, 0, 0, 0));
    load_cfg(cur_q, 4'd0, 4'd0, 4'd0);
    send(32'h0000FFFF, 32'h0000FFFF);
    wait_drain();
    check("t1_A", A, 64'h00000000FFFE0001);
    check("t1_Q", Q, 64'h80020001);

    // 2: q-1 squared, then a back-to-back accept in OUT
    send(32'h80020000, 32'h80020000);
    e1 = last_acc;
    send(32'h0, 32'h12345678);
    e2 = last_acc;
    check("t2_b2b_gap", 64'(e2 - e1), 64'(LAT));
    wait_drain();
    check("t2_A_zero", A, 64'd0);

    // 3: cfg write on the same edge as an accept
    cfg_we = 1'b1; cfg_q = 32'h7FFE0001; cfg_l1 = 4'd3; cfg_l2 = 4'd0; cfg_l3 = 4'd0;
    send(32'd3, 32'd5);
    cfg_we = 1'b0;
    wait_drain();
    check("t3_A", A, 64'd15);
    check("t3_Q_old", Q, 64'h80020001);
    send(32'd7, 32'd9);
    wait_drain();
    check("t3_Q_new", Q, 64'h7FFE0001);
    check("t3_l1_new", l1, 4'd3);

    // 4: valid_in held through MUL with changing operands
    send(32'h01234567, 32'h0BADF00D);
    valid_in = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      X = $urandom; Y = $urandom;
      @(negedge clk);
      check("t4_busy_ready", ready_in, 1'b0);
      tick();
    end
    valid_in = 1'b0;
    wait_drain();
    check("t4_A_latched", A, 64'h01234567 * 64'h0BADF00D);

    // 5: reset during the second MUL cycle
    send(32'h00ABCDEF, 32'h00FEDCBA);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t5_A", A, 64'd0);
    check("t5_Q", Q, 64'd0);
    check("t5_l1", l1, 4'd0);
    check("t5_valid", valid_out, 1'b0);
    check("t5_state", dbg_state, 2'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", ready_in, 1'b1);
    repeat (10) tick();
    check("t5_A_still_zero", A, 64'd0);

    // 6: random products, l3=7 for the USE_L3=0 copy, occasional legal cfg changes
    cur_q = 32'(k2red_q(32, 17, 0, 0, 7));
    load_cfg(cur_q, 4'd0, 4'd0, 4'd7);
    for (int i = 0; i < 1000; i++) begin
      if (i % 50 == 49) begin
        ra = 4'($urandom_range(12, 0));
        rb = 4'($urandom_range(12, 0));
        rc = 4'($urandom_range(12, 0));
        cur_q = 32'(k2red_q(32, 17, int'(ra), int'(rb), int'(rc)));
        load_cfg(cur_q, ra, rb, rc);
      end
      repeat ($urandom_range(1, 0)) tick();
      send($urandom_range(cur_q - 1, 0), $urandom_range(cur_q - 1, 0));
    end
    wait_drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
